// File: rtl/t06_multi_tick_gen.sv
// Multi-channel programmable tick generator: NCH independent IDLE/RUN counters, each with a one-cycle terminal tick.
// Optional per-channel 8-bit tick counters are enabled by defining T06_TICK_GEN_CNT_EN.
module t06_multi_tick_gen #(
  parameter int NCH   = 4,
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [NCH*WIDTH-1:0] max_i,
  input  logic [NCH-1:0]       en_i,
  input  logic [NCH-1:0]       oneshot_i,
  input  logic [NCH-1:0]       start_i,
  input  logic [NCH-1:0]       stop_i,
  output logic [NCH-1:0]       tick_o,
  output logic [NCH-1:0]       busy_o
`ifdef T06_TICK_GEN_CNT_EN
  ,
  output logic [NCH*8-1:0]     tick_cnt_o
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    state_t           state, state_nxt;
    logic [WIDTH-1:0] count, count_nxt;
    logic [WIDTH-1:0] max_k;
    logic             at_max;

    assign max_k  = max_i[k*WIDTH +: WIDTH];
    // Unsigned >= so a max lowered below the running count still terminates promptly.
    assign at_max = (count >= max_k);

    assign tick_o[k] = (state == RUN) && en_i[k] && at_max;
    assign busy_o[k] = (state == RUN);

    always_ff @(posedge clk) begin
      if (!nrst) begin
        state <= IDLE;
        count <= '0;
      end else begin
        state <= state_nxt;
        count <= count_nxt;
      end
    end

    always_comb begin
      state_nxt = state;
      count_nxt = count;
      case (state)
        IDLE: begin
          count_nxt = '0;
          if (start_i[k] && !stop_i[k]) state_nxt = RUN;
        end
        RUN: begin
          if (stop_i[k]) begin
            state_nxt = IDLE;
            count_nxt = '0;
          end else if (start_i[k]) begin
            count_nxt = '0;
          end else if (en_i[k]) begin
            if (at_max) begin
              count_nxt = '0;
              if (oneshot_i[k]) state_nxt = IDLE;
            end else begin
              count_nxt = count + ONE;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          count_nxt = '0;
        end
      endcase
    end

`ifdef T06_TICK_GEN_CNT_EN
    logic [7:0] tick_cnt;

    // A start on the channel clears the count even if a tick lands in the same cycle.
    always_ff @(posedge clk) begin
      if (!nrst)           tick_cnt <= 8'd0;
      else if (start_i[k]) tick_cnt <= 8'd0;
      else if (tick_o[k])  tick_cnt <= tick_cnt + 8'd1;
    end

    assign tick_cnt_o[k*8 +: 8] = tick_cnt;
`endif
  end

endmodule

// File: tb/tb_t06_multi_tick_gen.sv
// Bench for t06_multi_tick_gen: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_t06_multi_tick_gen;

  localparam int NCH   = 4;
  localparam int WIDTH = 16;

  logic                 clk;
  logic                 nrst;
  logic [NCH*WIDTH-1:0] max_i;
  logic [NCH-1:0]       en_i;
  logic [NCH-1:0]       oneshot_i;
  logic [NCH-1:0]       start_i;
  logic [NCH-1:0]       stop_i;
  logic [NCH-1:0]       tick_o;
  logic [NCH-1:0]       busy_o;
`ifdef T06_TICK_GEN_CNT_EN
  logic [NCH*8-1:0]     tick_cnt_o;
`endif

  t06_multi_tick_gen #(.NCH(NCH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .max_i     (max_i),
    .en_i      (en_i),
    .oneshot_i (oneshot_i),
    .start_i   (start_i),
    .stop_i    (stop_i),
    .tick_o    (tick_o),
    .busy_o    (busy_o)
`ifdef T06_TICK_GEN_CNT_EN
    ,
    .tick_cnt_o(tick_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: whether each channel is running, its enabled-cycle count, and ticks emitted.
  bit m_run [NCH];
  int m_cnt [NCH];
  int m_tc  [NCH];

  logic [NCH-1:0] obs_tick;

  function automatic int max_of(int k);
    return int'(max_i[k*WIDTH +: WIDTH]);
  endfunction

  function automatic logic [NCH-1:0] model_tick();
    logic [NCH-1:0] t;
    t = '0;
    for (int k = 0; k < NCH; k++)
      t[k] = m_run[k] && en_i[k] && (m_cnt[k] >= max_of(k));
    return t;
  endfunction

  function automatic logic [NCH-1:0] model_busy();
    logic [NCH-1:0] b;
    b = '0;
    for (int k = 0; k < NCH; k++) b[k] = m_run[k];
    return b;
  endfunction

  function automatic logic [NCH*8-1:0] model_tc();
    logic [NCH*8-1:0] v;
    v = '0;
    for (int k = 0; k < NCH; k++) v[k*8 +: 8] = 8'(m_tc[k]);
    return v;
  endfunction

  task automatic model_update();
    logic [NCH-1:0] t;
    t = model_tick();
    for (int k = 0; k < NCH; k++) begin
      if (!nrst) begin
        m_run[k] = 0; m_cnt[k] = 0; m_tc[k] = 0;
      end else begin
        if (start_i[k])  m_tc[k] = 0;
        else if (t[k])   m_tc[k] = (m_tc[k] + 1) % 256;
        if (!m_run[k]) begin
          if (start_i[k] && !stop_i[k]) begin m_run[k] = 1; m_cnt[k] = 0; end
        end else if (stop_i[k]) begin
          m_run[k] = 0; m_cnt[k] = 0;
        end else if (start_i[k]) begin
          m_cnt[k] = 0;
        end else if (en_i[k]) begin
          if (t[k]) begin m_cnt[k] = 0; m_run[k] = !oneshot_i[k]; end
          else m_cnt[k] = m_cnt[k] + 1;
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: outputs are compared mid-cycle, then the model follows the edge.
  task automatic applyStimulus();
    @(negedge clk);
    obs_tick = tick_o;
    checkOutput("tick_model", tick_o, model_tick());
    checkOutput("busy_model", busy_o, model_busy());
`ifdef T06_TICK_GEN_CNT_EN
    checkOutput("tcnt_model", tick_cnt_o, model_tc());
`endif
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    nrst = 1'b0; start_i = '1; stop_i = '0; en_i = '0; oneshot_i = '0;
    applyStimulus();
    applyStimulus();
    nrst = 1'b1; start_i = '0;
  endtask

  task automatic start_ch(input int k);
    start_i[k] = 1'b1;
    applyStimulus();
    start_i[k] = 1'b0;
  endtask

  initial begin
    nrst = 1'b0; max_i = '0; en_i = '0; oneshot_i = '0; start_i = '1; stop_i = '0;
    for (int k = 0; k < NCH; k++) begin m_run[k] = 0; m_cnt[k] = 0; m_tc[k] = 0; end
    @(posedge clk); #1;

    // Reset held with start asserted on every channel
    do_reset();
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_tick", obs_tick, 0);

    // Periodic ch0, max=3: ticks at 4,8,12,16,20
    max_i[0*WIDTH +: WIDTH] = 16'd3; en_i = 4'b0001; oneshot_i = '0;
    start_ch(0);
    for (int r = 1; r <= 20; r++) begin
      applyStimulus();
      checkOutput("periodic_tick", obs_tick[0], (r % 4 == 0));
    end
    checkOutput("periodic_busy", busy_o[0], 1);

    // One-shot ch1, max=5, enable on odd cycles only: single tick at 11
    do_reset();
    max_i[1*WIDTH +: WIDTH] = 16'd5; oneshot_i = 4'b0010;
    start_ch(1);
    for (int r = 1; r <= 20; r++) begin
      en_i[1] = (r % 2 == 1);
      applyStimulus();
      checkOutput("oneshot_tick", obs_tick[1], (r == 11));
    end
    checkOutput("oneshot_busy", busy_o[1], 0);

    // Retrigger ch2, max=10: starts at 0 and 7, first tick at 18
    do_reset();
    max_i[2*WIDTH +: WIDTH] = 16'd10; en_i = 4'b0100;
    start_ch(2);
    for (int r = 1; r <= 25; r++) begin
      start_i[2] = (r == 7);
      applyStimulus();
      checkOutput("retrig_tick", obs_tick[2], (r == 18));
    end
    start_i = '0;

    // Abort a fresh run on ch2 before its tick
    start_ch(2);
    for (int r = 1; r <= 20; r++) begin
      stop_i[2] = (r == 10);
      applyStimulus();
      checkOutput("abort_tick", obs_tick[2], 0);
      checkOutput("abort_busy", busy_o[2], (r < 10));
    end
    stop_i = '0;

    // max=0 on ch3: tick on every enabled cycle
    do_reset();
    max_i[3*WIDTH +: WIDTH] = 16'd0;
    start_ch(3);
    for (int r = 1; r <= 20; r++) begin
      en_i[3] = 1'($urandom_range(1));
      applyStimulus();
      checkOutput("max0_tick", obs_tick[3], en_i[3]);
    end

    // max lowered 10->2 while count=6: tick at 7, then 10, 13
    do_reset();
    max_i[0*WIDTH +: WIDTH] = 16'd10; en_i = 4'b0001;
    start_ch(0);
    for (int r = 1; r <= 14; r++) begin
      if (r == 7) max_i[0*WIDTH +: WIDTH] = 16'd2;
      applyStimulus();
      checkOutput("lower_tick", obs_tick[0], (r == 7 || r == 10 || r == 13));
    end

    // Four channels at once, max=1..4: periods 2..5
    do_reset();
    for (int k = 0; k < NCH; k++) max_i[k*WIDTH +: WIDTH] = 16'(k + 1);
    en_i = '1;
    start_i = '1;
    applyStimulus();
    start_i = '0;
    for (int r = 1; r <= 30; r++) begin
      applyStimulus();
      for (int k = 0; k < NCH; k++)
        checkOutput("indep_tick", obs_tick[k], (r % (k + 2) == 0));
    end

`ifdef T06_TICK_GEN_CNT_EN
    // Tick counter on ch0 wraps 255->0 after 256 ticks
    do_reset();
    max_i[0*WIDTH +: WIDTH] = 16'd0; en_i = 4'b0001;
    start_ch(0);
    for (int r = 1; r <= 256; r++) begin
      applyStimulus();
      if (r == 255) checkOutput("tcnt_255", tick_cnt_o[7:0], 8'd255);
    end
    checkOutput("tcnt_wrap", tick_cnt_o[7:0], 8'd0);
`endif

    // Randomized traffic on all channels
    do_reset();
    for (int r = 0; r < 3000; r++) begin
      if (r % 50 == 0)
        for (int k = 0; k < NCH; k++) max_i[k*WIDTH +: WIDTH] = 16'($urandom_range(15));
      en_i      = NCH'($urandom);
      oneshot_i = NCH'($urandom);
      for (int k = 0; k < NCH; k++) begin
        start_i[k] = ($urandom_range(15) == 0);
        stop_i[k]  = ($urandom_range(31) == 0);
      end
      applyStimulus();
    end
    start_i = '0; stop_i = '0;

    // Full-width terminal value: tick only after 65536 enabled cycles
    do_reset();
    max_i[0*WIDTH +: WIDTH] = 16'hFFFF; en_i = 4'b0001;
    start_ch(0);
    for (int r = 1; r <= 65537; r++) begin
      applyStimulus();
      if (r >= 65530) checkOutput("maxfull_tick", obs_tick[0], (r == 65536));
      else if (obs_tick[0]) checkOutput("maxfull_early", obs_tick[0], 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
